// File: rtl/mux_arbitro_rr.sv
// Round-robin arbiter for two valid/ready lanes feeding a registered mux,
// with burst limiting and per-lane transfer counters.
module mux_arbitro_rr #(
    parameter int unsigned BURST_MAX = 2,
    parameter int unsigned DATA_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid0,
    input  logic [DATA_W-1:0] data_in0,
    output logic              ready0,
    input  logic              valid1,
    input  logic [DATA_W-1:0] data_in1,
    output logic              ready1,
    input  logic              ready_out,
    output logic              valid_out,
    output logic [DATA_W-1:0] data_out,
    output logic              selector,
    output logic [3:0]        count0,
    output logic [3:0]        count1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t     state, state_nxt;
    logic [3:0] run, run_nxt;
    logic       last, last_nxt;
    logic       gnt, g;
    logic       can_accept, xfer;

    assign can_accept = !valid_out || ready_out;
    assign xfer       = gnt && can_accept;
    assign ready0     = !reset && xfer && !g;
    assign ready1     = !reset && xfer && g;

    // Owner keeps the lane until its burst runs out and the other lane waits
    always_comb begin
        gnt = 1'b0;
        g   = 1'b0;
        unique case (state)
            IDLE: begin
                gnt = valid0 || valid1;
                g   = (valid0 && valid1) ? !last : valid1;
            end
            OWN0: begin
                if (valid0 && (run < BMAX || !valid1)) begin
                    gnt = 1'b1;
                    g   = 1'b0;
                end else if (valid1) begin
                    gnt = 1'b1;
                    g   = 1'b1;
                end
            end
            OWN1: begin
                if (valid1 && (run < BMAX || !valid0)) begin
                    gnt = 1'b1;
                    g   = 1'b1;
                end else if (valid0) begin
                    gnt = 1'b1;
                    g   = 1'b0;
                end
            end
            default: begin
                gnt = 1'b0;
                g   = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        last_nxt  = last;
        if (xfer) begin
            state_nxt = g ? OWN1 : OWN0;
            last_nxt  = g;
            if (state == state_nxt)
                run_nxt = (run == 4'hf) ? run : run + 4'd1;
            else
                run_nxt = 4'd1;
        end else if (can_accept) begin
            state_nxt = IDLE;
            run_nxt   = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            run       <= 4'd0;
            last      <= 1'b1;
            valid_out <= 1'b0;
            data_out  <= '0;
            selector  <= 1'b0;
            count0    <= 4'd0;
            count1    <= 4'd0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            last  <= last_nxt;
            if (xfer) begin
                data_out  <= g ? data_in1 : data_in0;
                selector  <= g;
                valid_out <= 1'b1;
                if (g)
                    count1 <= count1 + 4'd1;
                else
                    count0 <= count0 + 4'd1;
            end else if (can_accept) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbitro_rr.sv
// Randomized and directed checks of mux_arbitro_rr against a lane-level
// round-robin model.
module tb_mux_arbitro_rr;

    localparam int BURST = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid0 = 1'b0, valid1 = 1'b0, ready_out = 1'b0;
    logic [1:0] data_in0 = '0, data_in1 = '0;
    logic       ready0, ready1, valid_out, selector;
    logic [1:0] data_out;
    logic [3:0] count0, count1;

    int n_chk = 0;
    int n_err = 0;

    // model state: owner -1 means no owner
    int m_owner, m_run, m_last, m_vout, m_dout, m_sel;
    int m_cnt [2];

    mux_arbitro_rr #(.BURST_MAX(BURST), .DATA_W(2)) dut (
        .clk(clk), .reset(reset),
        .valid0(valid0), .data_in0(data_in0), .ready0(ready0),
        .valid1(valid1), .data_in1(data_in1), .ready1(ready1),
        .ready_out(ready_out), .valid_out(valid_out),
        .data_out(data_out), .selector(selector),
        .count0(count0), .count1(count1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(int v0, int v1);
        int mine, other;
        if (m_owner < 0) begin
            if (v0 != 0 && v1 != 0) return 1 - m_last;
            if (v0 != 0) return 0;
            if (v1 != 0) return 1;
            return -1;
        end
        mine  = (m_owner == 1) ? v1 : v0;
        other = (m_owner == 1) ? v0 : v1;
        if (mine != 0 && (m_run < BURST || other == 0)) return m_owner;
        if (other != 0) return 1 - m_owner;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_run = 0; m_last = 1;
        m_vout = 0; m_dout = 0; m_sel = 0;
        m_cnt[0] = 0; m_cnt[1] = 0;
    endtask

    // One cycle: drive, check readies, clock, check registered outputs
    task automatic step(input int v0, input int d0, input int v1,
                        input int d1, input int ro, input int rst,
                        output int og);
        int g, ca;
        @(negedge clk);
        valid0 = v0[0]; data_in0 = d0[1:0];
        valid1 = v1[0]; data_in1 = d1[1:0];
        ready_out = ro[0]; reset = rst[0];
        #1;
        ca = (m_vout == 0 || ro != 0) ? 1 : 0;
        g  = pick(v0, v1);
        chk("ready0", 32'(ready0), 32'(rst == 0 && ca != 0 && g == 0));
        chk("ready1", 32'(ready1), 32'(rst == 0 && ca != 0 && g == 1));
        og = ready0 ? 0 : (ready1 ? 1 : -1);
        @(posedge clk);
        if (rst != 0) begin
            model_reset();
        end else if (ca != 0) begin
            if (g >= 0) begin
                m_dout = (g == 1) ? d1 : d0;
                m_sel  = g;
                m_vout = 1;
                m_cnt[g] = (m_cnt[g] + 1) % 16;
                m_run  = (m_owner == g) ? ((m_run < 15) ? m_run + 1 : 15) : 1;
                m_owner = g;
                m_last = g;
            end else begin
                m_owner = -1;
                m_run = 0;
                m_vout = 0;
            end
        end
        #1;
        chk("valid_out", 32'(valid_out), 32'(m_vout));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("selector", 32'(selector), 32'(m_sel));
        chk("count0", 32'(count0), 32'(m_cnt[0]));
        chk("count1", 32'(count1), 32'(m_cnt[1]));
    endtask

    initial begin
        int og;
        int fair [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        model_reset();

        // reset held with both lanes requesting
        step(1, 1, 1, 2, 1, 1, og);
        step(1, 1, 1, 2, 1, 1, og);

        // single lane stream
        step(1, 1, 0, 0, 1, 0, og);
        step(1, 2, 0, 0, 1, 0, og);
        step(1, 3, 0, 0, 1, 0, og);
        step(0, 0, 0, 0, 1, 0, og);
        chk("single_cnt0", 32'(count0), 32'd3);

        // fair share from reset
        step(0, 0, 0, 0, 1, 1, og);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 1, 2, 1, 0, og);
            chk("fair_grant", 32'(og), 32'(fair[i]));
        end
        chk("fair_cnt0", 32'(count0), 32'd4);
        chk("fair_cnt1", 32'(count1), 32'd4);

        // backpressure mid-burst, then resume
        step(1, 3, 1, 1, 1, 0, og);
        chk("bp_first", 32'(og), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 2, 1, 1, 0, 0, og);
            chk("bp_stall", 32'(og), 32'hffffffff);
        end
        step(1, 2, 1, 1, 1, 0, og);
        chk("bp_resume", 32'(og), 32'd0);
        step(1, 2, 1, 1, 1, 0, og);
        chk("bp_switch", 32'(og), 32'd1);

        // lone requester, then drain
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, i % 4, 1, 0, og);
            chk("lone_grant", 32'(og), 32'd1);
        end
        step(0, 0, 0, 0, 1, 0, og);
        chk("lone_drain", 32'(valid_out), 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 60) == 0), og);
        end

        // counter wrap
        step(0, 0, 0, 0, 1, 1, og);
        for (int i = 0; i < 17; i++) step(1, i % 4, 0, 0, 1, 0, og);
        chk("wrap_cnt0", 32'(count0), 32'd1);

        // reset during a lane-1 burst clears history
        step(0, 0, 1, 1, 1, 0, og);
        step(0, 0, 1, 2, 1, 0, og);
        step(0, 0, 1, 3, 1, 1, og);
        step(1, 1, 1, 2, 1, 0, og);
        chk("post_reset_grant", 32'(og), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
